branch_unit: RTL and testbench

Conditional-branch resolution unit for the 16-bit datapath, placed in the instruction-decode (ID) stage. It compares a source register value against the R0 comparison register according to the 4-bit opcode and produces the next PC. On a taken branch the next PC is `pc + offset`; otherwise it is the sequential `pc + 2`. Results are registered, giving one-cycle latency to the fetch stage.

---
 rtl/branch_pkg.sv | 11 +
 rtl/branch_cmp.sv | 17 +
 rtl/branch_unit.sv | 64 ++++++
 tb/tb_branch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants for the ID-stage branch resolution unit.
// Opcodes and default datapath width.
package branch_pkg;

  localparam int BR_W = 16;

  localparam logic [3:0] OP_BLT = 4'b0100;
  localparam logic [3:0] OP_BGT = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b0110;

endpackage

// File: rtl/branch_cmp.sv
// Combinational two's-complement comparator.
// Flags relate rd1 to r0r.
module branch_cmp #(
  parameter int W = 16
) (
  input  logic [W-1:0] rd1,
  input  logic [W-1:0] r0r,
  output logic         lt,
  output logic         gt,
  output logic         eq
);

  assign lt = $signed(rd1) < $signed(r0r);
  assign gt = $signed(rd1) > $signed(r0r);
  assign eq = rd1 == r0r;

endmodule

// File: rtl/branch_unit.sv
// Branch decision and next-PC select for the ID stage.
// Outputs are registered: one-cycle latency to fetch.
module branch_unit
  import branch_pkg::*;
#(
  parameter int W       = BR_W,
  parameter int PC_STEP = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [3:0]   op_code,
  input  logic [W-1:0] rd1,
  input  logic [W-1:0] r0r,
  input  logic [W-1:0] pc,
  input  logic [W-1:0] offset,
  output logic         out_valid,
  output logic         taken,
  output logic [W-1:0] branch
);

  logic         lt;
  logic         gt;
  logic         eq;
  logic         hit;
  logic         taken_d;
  logic [W-1:0] target;

  branch_cmp #(.W(W)) u_cmp (
    .rd1 (rd1),
    .r0r (r0r),
    .lt  (lt),
    .gt  (gt),
    .eq  (eq)
  );

  always_comb begin
    hit = 1'b0;
    unique case (op_code)
      OP_BLT:  hit = lt;
      OP_BGT:  hit = gt;
      OP_BEQ:  hit = eq;
      default: hit = 1'b0;
    endcase
  end

  // An invalid slot is never taken; it falls through.
  assign taken_d = in_valid & hit;
  assign target  = taken_d ? pc + offset
                           : pc + W'(PC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      taken     <= 1'b0;
      branch    <= '0;
    end else begin
      out_valid <= in_valid;
      taken     <= taken_d;
      branch    <= target;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit.
// Vector table plus reset and back-to-back sequences.
module tb_branch_unit;
  import branch_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   op_code = '0;
  logic [W-1:0] rd1 = '0;
  logic [W-1:0] r0r = '0;
  logic [W-1:0] pc = '0;
  logic [W-1:0] offset = '0;
  logic         out_valid;
  logic         taken;
  logic [W-1:0] branch;

  int ntests = 0;
  int nfail  = 0;

  branch_unit #(.W(W), .PC_STEP(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op_code   (op_code),
    .rd1       (rd1),
    .r0r       (r0r),
    .pc        (pc),
    .offset    (offset),
    .out_valid (out_valid),
    .taken     (taken),
    .branch    (branch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] pc;
    logic [W-1:0] off;
    logic         et;
    logic [W-1:0] eb;
  } vec_t;

  typedef struct {
    logic         v;
    logic         t;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[14];

  task automatic check(string name, logic [W-1:0] act,
                       logic [W-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(vec_t x);
    exp_t e;
    logic c;
    c = 1'b0;
    if (x.op == 4'b0100) c = $signed(x.a) < $signed(x.b);
    if (x.op == 4'b0101) c = $signed(x.a) > $signed(x.b);
    if (x.op == 4'b0110) c = x.a == x.b;
    e.v = x.v;
    e.t = x.v & c;
    e.b = e.t ? x.pc + x.off : x.pc + 16'd2;
    return e;
  endfunction

  task automatic drive(vec_t x);
    in_valid = x.v;
    op_code  = x.op;
    rd1      = x.a;
    r0r      = x.b;
    pc       = x.pc;
    offset   = x.off;
  endtask

  task automatic compare(string name);
    exp_t e;
    if (sb.size() == 0) begin
      ntests++;
      nfail++;
      $display("FAIL %s: scoreboard empty, got none expected 1", name);
    end else begin
      e = sb.pop_front();
      check({name, ".valid"}, W'(out_valid), W'(e.v));
      check({name, ".taken"}, W'(taken), W'(e.t));
      check({name, ".branch"}, branch, e.b);
    end
  endtask

  task automatic apply(vec_t x, string name);
    exp_t e;
    @(negedge clk);
    drive(x);
    e.v = x.v;
    e.t = x.et;
    e.b = x.eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic check_zero(string name);
    check({name, ".valid"}, W'(out_valid), '0);
    check({name, ".taken"}, W'(taken), '0);
    check({name, ".branch"}, branch, '0);
  endtask

  initial begin
    vec_t x;
    exp_t e;

    tbl[0]  = '{1'b1, OP_BLT, 16'd2, 16'd1, 16'h0000, 16'd4, 1'b0, 16'd2};
    tbl[1]  = '{1'b1, OP_BLT, 16'd1, 16'd2, 16'h0000, 16'd4, 1'b1, 16'd4};
    tbl[2]  = '{1'b1, OP_BGT, 16'd1, 16'd2, 16'h0000, 16'd4, 1'b0, 16'd2};
    tbl[3]  = '{1'b1, OP_BGT, 16'd2, 16'd1, 16'h0000, 16'd4, 1'b1, 16'd4};
    tbl[4]  = '{1'b1, OP_BEQ, 16'd1, 16'd2, 16'h0000, 16'd4, 1'b0, 16'd2};
    tbl[5]  = '{1'b1, OP_BEQ, 16'd1, 16'd1, 16'h0000, 16'd4, 1'b1, 16'd4};
    tbl[6]  = '{1'b1, OP_BLT, 16'h8000, 16'd1, 16'h0010, 16'hFFF0,
                1'b1, 16'h0000};
    tbl[7]  = '{1'b1, 4'b0000, 16'd5, 16'd5, 16'hFFFE, 16'd8,
                1'b0, 16'h0000};
    tbl[8]  = '{1'b1, OP_BLT, 16'd7, 16'd7, 16'h0020, 16'd8,
                1'b0, 16'h0022};
    tbl[9]  = '{1'b1, OP_BGT, 16'd7, 16'd7, 16'h0020, 16'd8,
                1'b0, 16'h0022};
    tbl[10] = '{1'b1, OP_BGT, 16'h8000, 16'd1, 16'h0040, 16'd8,
                1'b0, 16'h0042};
    tbl[11] = '{1'b1, OP_BEQ, 16'hABCD, 16'hABCD, 16'h0100, 16'hFFFC,
                1'b1, 16'h00FC};
    tbl[12] = '{1'b1, 4'b0111, 16'd3, 16'd3, 16'h0200, 16'd8,
                1'b0, 16'h0202};
    tbl[13] = '{1'b0, OP_BEQ, 16'd3, 16'd3, 16'h0300, 16'd8,
                1'b0, 16'h0302};

    // reset held with random valid inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op_code  = 4'($urandom_range(4, 6));
      rd1      = 16'($urandom);
      r0r      = 16'($urandom);
      pc       = 16'($urandom);
      offset   = 16'($urandom);
      @(posedge clk);
      #1;
      check_zero($sformatf("reset%0d", i));
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // back-to-back alternating taken / not taken, one idle slot
    for (int i = 0; i < 10; i++) begin
      x.v   = (i != 6);
      x.op  = OP_BEQ;
      x.a   = 16'($urandom);
      x.b   = (i % 2 == 0) ? x.a : x.a ^ 16'h0001;
      x.pc  = 16'($urandom) & 16'hFFFE;
      x.off = 16'($urandom) & 16'hFFFE;
      e = model(x);
      x.et = e.t;
      x.eb = e.b;
      apply(x, $sformatf("b2b%0d", i));
    end

    // asynchronous reset mid-cycle after a taken result
    x = tbl[1];
    apply(x, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("async_hold");

    // in-flight capture discarded by reset before the edge
    @(negedge clk);
    rst_n = 1'b1;
    drive(tbl[3]);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_zero("inflight");

    @(negedge clk);
    rst_n = 1'b1;
    apply(tbl[11], "recover");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
